lsu_arbiter: RTL and testbench

Two-requester arbiter and burst sequencer in front of the single-port LSU (DMEM 0x0000–0x07FF, I/O 0x7000–0x703F). Requester 0 is the core data port; requester 1 is the debug/DMA port. The block grants one requester at a time round-robin, expands a burst into consecutive word accesses on the LSU port, and returns read data and a completion pulse per requester.

---
 rtl/lsu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_lsu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter and burst sequencer in front of the single-port LSU.
// A granted burst is expanded into one word access per cycle; reads return one cycle later.

module lsu_arb_resp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_beat,
    input  logic              last_beat,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              done
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            rvalid <= rd_beat;
            done   <= last_beat;
            if (rd_beat) rdata <= r_data;
        end
    end
endmodule

module lsu_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int BLEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    output logic              m0_gnt,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wr_en,
    input  logic [3:0]        m0_bmask,
    input  logic [2:0]        m0_ld_sel,
    input  logic [BLEN_W-1:0] m0_blen,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_beat,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_done,
    input  logic              m1_req,
    output logic              m1_gnt,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wr_en,
    input  logic [3:0]        m1_bmask,
    input  logic [2:0]        m1_ld_sel,
    input  logic [BLEN_W-1:0] m1_blen,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_beat,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_done,
    output logic [ADDR_W-1:0] lsu_addr,
    output logic [DATA_W-1:0] lsu_w_data,
    output logic              lsu_wr_en,
    output logic [3:0]        lsu_bmask,
    output logic [2:0]        lsu_ld_sel,
    input  logic [DATA_W-1:0] lsu_r_data
);
    localparam int NUM_M = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr_en;
        logic [3:0]        bmask;
        logic [2:0]        ld_sel;
        logic [BLEN_W-1:0] blen;
    } burst_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                         state;
    logic                           rr_ptr;
    logic                           owner;
    logic [BLEN_W-1:0]              beat_cnt;
    burst_t                         cur;

    burst_t [NUM_M-1:0]             req_b;
    logic   [NUM_M-1:0][DATA_W-1:0] wdata;
    logic   [NUM_M-1:0]             req, gnt, beat;
    logic   [NUM_M-1:0][DATA_W-1:0] rdata_v;
    logic   [NUM_M-1:0]             rvalid_v, done_v;
    logic                           pick, active, last;

    assign req      = {m1_req, m0_req};
    assign wdata    = {m1_wdata, m0_wdata};
    assign req_b[0] = '{addr: m0_addr, wr_en: m0_wr_en, bmask: m0_bmask, ld_sel: m0_ld_sel, blen: m0_blen};
    assign req_b[1] = '{addr: m1_addr, wr_en: m1_wr_en, bmask: m1_bmask, ld_sel: m1_ld_sel, blen: m1_blen};

    // Preferred master wins unless it is not asking; the pointer then moves past the winner.
    always_comb begin
        pick = rr_ptr;
        if (!req[rr_ptr]) pick = ~rr_ptr;
    end

    // A low rst_n cancels the current cycle's beat so nothing is committed while resetting.
    assign active = (state == BUSY) && rst_n;
    assign last   = active && (beat_cnt == cur.blen);
    assign gnt    = ((state == IDLE) && (|req) && rst_n) ? NUM_M'(1) << pick : '0;
    assign beat   = active ? NUM_M'(1) << owner : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            beat_cnt <= '0;
            cur      <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    owner    <= pick;
                    rr_ptr   <= ~pick;
                    cur      <= req_b[pick];
                    beat_cnt <= '0;
                    state    <= BUSY;
                end
                BUSY: begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == cur.blen) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        lsu_addr   = '0;
        lsu_w_data = '0;
        lsu_wr_en  = 1'b0;
        lsu_bmask  = '0;
        lsu_ld_sel = '0;
        if (active) begin
            lsu_addr   = cur.addr + ADDR_W'({beat_cnt, 2'b00});
            lsu_w_data = wdata[owner];
            lsu_wr_en  = cur.wr_en;
            lsu_bmask  = cur.bmask;
            lsu_ld_sel = cur.ld_sel;
        end
    end

    for (genvar i = 0; i < NUM_M; i++) begin : g_resp
        lsu_arb_resp #(.DATA_W(DATA_W)) u_resp (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_beat  (beat[i] & ~cur.wr_en),
            .last_beat(beat[i] & last),
            .r_data   (lsu_r_data),
            .rdata    (rdata_v[i]),
            .rvalid   (rvalid_v[i]),
            .done     (done_v[i])
        );
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_beat   = beat[0];
    assign m1_beat   = beat[1];
    assign m0_rdata  = rdata_v[0];
    assign m1_rdata  = rdata_v[1];
    assign m0_rvalid = rvalid_v[0];
    assign m1_rvalid = rvalid_v[1];
    assign m0_done   = done_v[0];
    assign m1_done   = done_v[1];
endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: word-addressed LSU memory model, table-driven bursts,
// hand-written arbitration/reset sequences and randomized bursts against a shadow model.

module tb_lsu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req = '0;
    logic [15:0] m_addr [2];
    logic        m_wr   [2];
    logic [3:0]  m_bm   [2];
    logic [2:0]  m_ls   [2];
    logic [3:0]  m_blen [2];
    logic [31:0] m_wd   [2];

    wire  [1:0]  gnt, beat, rvalid, done;
    wire  [31:0] rdata0, rdata1;
    wire  [15:0] lsu_addr;
    wire  [31:0] lsu_w_data, lsu_r_data;
    wire         lsu_wr_en;
    wire  [3:0]  lsu_bmask;
    wire  [2:0]  lsu_ld_sel;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];

    lsu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_gnt(gnt[0]), .m0_addr(m_addr[0]), .m0_wr_en(m_wr[0]),
        .m0_bmask(m_bm[0]), .m0_ld_sel(m_ls[0]), .m0_blen(m_blen[0]), .m0_wdata(m_wd[0]),
        .m0_beat(beat[0]), .m0_rdata(rdata0), .m0_rvalid(rvalid[0]), .m0_done(done[0]),
        .m1_req(req[1]), .m1_gnt(gnt[1]), .m1_addr(m_addr[1]), .m1_wr_en(m_wr[1]),
        .m1_bmask(m_bm[1]), .m1_ld_sel(m_ls[1]), .m1_blen(m_blen[1]), .m1_wdata(m_wd[1]),
        .m1_beat(beat[1]), .m1_rdata(rdata1), .m1_rvalid(rvalid[1]), .m1_done(done[1]),
        .lsu_addr(lsu_addr), .lsu_w_data(lsu_w_data), .lsu_wr_en(lsu_wr_en),
        .lsu_bmask(lsu_bmask), .lsu_ld_sel(lsu_ld_sel), .lsu_r_data(lsu_r_data)
    );

    function automatic logic [31:0] pattern(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] bm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // LSU model: combinational read, byte-masked write at the clock edge.
    assign lsu_r_data = mem[lsu_addr[15:2]];
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = pattern(i);
        mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33; mem[7] = 32'h44;
        forever begin
            @(posedge clk);
            if (lsu_wr_en) mem[lsu_addr[15:2]] <= merge(mem[lsu_addr[15:2]], lsu_w_data, lsu_bmask);
        end
    end

    function automatic logic [31:0] rd_of(int w);
        return (w != 0) ? rdata1 : rdata0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_lsu_quiet(input string nm);
        chk({nm, ".lsu_addr"}, 32'(lsu_addr), 32'h0);
        chk({nm, ".lsu_wr_en"}, 32'(lsu_wr_en), 32'h0);
        chk({nm, ".lsu_w_data"}, lsu_w_data, 32'h0);
        chk({nm, ".lsu_bmask_ldsel"}, {25'h0, lsu_bmask, lsu_ld_sel}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        #1;
        chk("rst.gnt_beat", {28'h0, gnt, beat}, 32'h0);
        chk("rst.rvalid_done", {28'h0, rvalid, done}, 32'h0);
        chk("rst.rdata0", rdata0, 32'h0);
        chk("rst.rdata1", rdata1, 32'h0);
        chk_lsu_quiet("rst");
        rst_n = 1'b1;
    endtask

    function automatic void rand_params(int w);
        m_addr[w] = 16'($urandom);
        m_wr[w]   = 1'($urandom);
        m_bm[w]   = 4'($urandom);
        m_ls[w]   = 3'($urandom);
        m_blen[w] = 4'($urandom);
        m_wd[w]   = $urandom;
    endfunction

    // Entered just after a negedge with the DUT idle; returns just after the done-cycle negedge.
    task automatic run_burst(input logic [1:0] rmask, input int who, input bit wr,
                             input logic [15:0] base, input logic [3:0] blen,
                             input logic [3:0] bm, input logic [2:0] ls,
                             input logic [31:0] wd0, output logic [15:0] last_a);
        logic [1:0]  oh;
        logic [15:0] a;
        logic [31:0] exp_rd;
        bit          pend;
        oh = 2'(1 << who);
        m_addr[who] = base; m_wr[who] = wr; m_bm[who] = bm; m_ls[who] = ls; m_blen[who] = blen;
        req = rmask;
        #1;
        chk("gnt", 32'(gnt), 32'(oh));
        @(negedge clk);
        req    = '0;
        pend   = 1'b0;
        exp_rd = '0;
        last_a = '0;
        for (int k = 0; k <= int'(blen); k++) begin
            a = base + 16'(4 * k);
            m_wd[who] = wd0 + 32'(k) * 32'h01010101;
            #1;
            chk("beat.addr", 32'(lsu_addr), 32'(a));
            chk("beat.wr_en", 32'(lsu_wr_en), 32'(wr));
            chk("beat.w_data", lsu_w_data, m_wd[who]);
            chk("beat.bmask_ldsel", {25'h0, lsu_bmask, lsu_ld_sel}, {25'h0, bm, ls});
            chk("beat.beat_gnt", {28'h0, beat, gnt}, {28'h0, oh, 2'b00});
            chk("beat.rvalid", 32'(rvalid), pend ? 32'(oh) : 32'h0);
            if (pend) chk("beat.rdata", rd_of(who), exp_rd);
            if (!wr) begin
                exp_rd = ref_mem[a[15:2]];
                pend   = 1'b1;
            end else begin
                ref_mem[a[15:2]] = merge(ref_mem[a[15:2]], m_wd[who], bm);
            end
            last_a = lsu_addr;
            @(negedge clk);
        end
        #1;
        chk("end.done", 32'(done), 32'(oh));
        chk("end.rvalid", 32'(rvalid), wr ? 32'h0 : 32'(oh));
        if (!wr) chk("end.rdata", rd_of(who), exp_rd);
        chk("end.beat_gnt", {28'h0, beat, gnt}, 32'h0);
        chk_lsu_quiet("end");
        if (wr)
            for (int k = 0; k <= int'(blen); k++) begin
                a = base + 16'(4 * k);
                chk("end.mem", mem[a[15:2]], ref_mem[a[15:2]]);
            end
    endtask

    typedef struct {
        int          who;
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  blen;
        logic [3:0]  bm;
        logic [2:0]  ls;
        logic [31:0] wd0;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [15:0] la;
        logic [1:0]  rm;
        int          who, other, pref;
        logic [1:0]  exp_g [8];
        logic [1:0]  exp_d [8];

        for (int i = 0; i < 16384; i++) ref_mem[i] = pattern(i);
        ref_mem[4] = 32'h11; ref_mem[5] = 32'h22; ref_mem[6] = 32'h33; ref_mem[7] = 32'h44;
        for (int w = 0; w < 2; w++) rand_params(w);

        vt[0] = '{0, 1'b1, 16'h7000, 4'd0,  4'hF, 3'b000, 32'hDEADBEEF, 16'h7000};
        vt[1] = '{1, 1'b0, 16'h0010, 4'd3,  4'hF, 3'b010, 32'h0,        16'h001C};
        vt[2] = '{0, 1'b0, 16'hFFFC, 4'd1,  4'hF, 3'b010, 32'h0,        16'h0000};
        vt[3] = '{1, 1'b1, 16'h0201, 4'd2,  4'h5, 3'b001, 32'hA5A5C3C3, 16'h0209};
        vt[4] = '{0, 1'b0, 16'h7030, 4'd15, 4'hF, 3'b100, 32'h0,        16'h706C};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            other = 1 - vt[i].who;
            rand_params(other);
            run_burst(2'(1 << vt[i].who), vt[i].who, vt[i].wr, vt[i].addr, vt[i].blen,
                      vt[i].bm, vt[i].ls, vt[i].wd0, la);
            chk("tbl.last_addr", 32'(la), 32'(vt[i].exp_last));
            if (i == 0) chk("tbl.io_ledr", mem[16'h7000 >> 2], 32'hDEADBEEF);
            if (i == 1) chk("tbl.m1_last_rdata", rdata1, 32'h44);
        end

        // Both masters hold req with single-beat reads: grants alternate with one idle gap.
        do_reset();
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_d = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int w = 0; w < 2; w++) begin
            m_addr[w] = 16'h0020 + 16'(w * 4); m_wr[w] = 1'b0; m_blen[w] = 4'd0;
        end
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr.gnt", 32'(gnt), 32'(exp_g[i]));
            chk("rr.done", 32'(done), 32'(exp_d[i]));
            if (i == 7) req = '0;
            @(negedge clk);
        end
        #1;
        chk("rr.tail_done_gnt", {28'h0, done, gnt}, {28'h0, 2'b10, 2'b00});

        // Req dropped right after grant: the burst still runs to completion, no regrant.
        run_burst(2'b01, 0, 1'b0, 16'h0040, 4'd2, 4'hF, 3'b010, 32'h0, la);
        chk("drop.last_addr", 32'(la), 32'h0048);
        @(negedge clk);
        #1;
        chk("drop.no_regrant", {28'h0, gnt, beat}, 32'h0);

        // Reset asserted during beat 3 of an 8-beat write.
        m_addr[1] = 16'h0100; m_wr[1] = 1'b1; m_bm[1] = 4'hF; m_ls[1] = 3'b000; m_blen[1] = 4'd7;
        req = 2'b10;
        #1;
        chk("rstmid.gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            m_wd[1] = 32'hA0 + 32'(k);
            #1;
            chk("rstmid.beat", 32'(beat), 32'h2);
            ref_mem[(16'h0100 >> 2) + k] = m_wd[1];
            @(negedge clk);
        end
        m_wd[1] = 32'hA3;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid.after_outs", {28'h0, gnt, beat}, 32'h0);
        chk("rstmid.after_rv_done", {28'h0, rvalid, done}, 32'h0);
        chk("rstmid.after_rdata1", rdata1, 32'h0);
        chk_lsu_quiet("rstmid");
        @(negedge clk);
        #1;
        chk("rstmid.no_done", 32'(done), 32'h0);
        chk("rstmid.w100", mem[16'h0100 >> 2], 32'hA0);
        chk("rstmid.w108", mem[16'h0108 >> 2], 32'hA2);
        chk("rstmid.w10C_untouched", mem[16'h010C >> 2], pattern(16'h010C >> 2));
        m_addr[0] = 16'h0030; m_wr[0] = 1'b0; m_blen[0] = 4'd0;
        req = 2'b11;
        #1;
        chk("rstmid.post_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #1;
        chk("rstmid.post_done", 32'(done), 32'h1);

        // Randomized bursts; winner predicted from the round-robin rule alone.
        do_reset();
        pref = 0;
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 2; w++) rand_params(w);
            rm  = 2'($urandom_range(1, 3));
            who = (rm == 2'b11) ? pref : ((rm == 2'b10) ? 1 : 0);
            pref = 1 - who;
            run_burst(rm, who, m_wr[who], m_addr[who], m_blen[who], m_bm[who], m_ls[who],
                      m_wd[who], la);
            chk("rnd.last_addr", 32'(la), 32'(m_addr[who] + 16'(4 * int'(m_blen[who]))));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1;
                chk("rnd.idle", {28'h0, gnt, beat}, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
